sata_axil_master: RTL and testbench
===================================

SATA_AXIL_MASTER -- requirements
Module: sata_axil_master

Interface
REQ-001 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: AXI4-Lite data width (only 32 supported).
REQ-002 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 5: AXI4-Lite address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 256: cycles allowed per transaction before abort; must be >= 2.
REQ-004 The block SHALL have port M_AXI_ACLK, in, 1: the single clock.
REQ-005 The block SHALL have port M_AXI_ARESETN, in, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port cmd_valid, in, 1, and cmd_ready, out, 1: command handshake.
REQ-007 The block SHALL have port cmd_write, in, 1: 1 = write, 0 = read.
REQ-008 The block SHALL have ports cmd_addr (in, ADDR_W), cmd_wdata (in, DATA_W) and cmd_wstrb (in, DATA_W/8).
REQ-009 The block SHALL have ports rsp_valid (out, 1) and rsp_ready (in, 1): response handshake.
REQ-010 The block SHALL have ports rsp_write (out, 1), rsp_rdata (out, DATA_W), rsp_resp (out, 2) and rsp_timeout (out, 1).
REQ-011 The AW channel SHALL be M_AXI_AWADDR out ADDR_W, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-012 The W channel SHALL be M_AXI_WDATA out DATA_W, M_AXI_WSTRB out DATA_W/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-013 The B channel SHALL be M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-014 The AR channel SHALL be M_AXI_ARADDR out ADDR_W, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
REQ-015 The R channel SHALL be M_AXI_RDATA in DATA_W, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-016 The block SHALL have FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RSP.
REQ-017 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready the block SHALL latch cmd_* and go to WR_ADDR_DATA (write) or RD_ADDR (read).
REQ-018 In WR_ADDR_DATA, AWVALID and WVALID SHALL be asserted together in the first cycle after the command is accepted.
REQ-019 In WR_ADDR_DATA, each of AWVALID and WVALID SHALL drop independently the cycle after its own ready is sampled high (aw_done/w_done flags); the block SHALL go to WR_RESP once both are done, including the case where both complete in the same cycle.
REQ-020 BREADY SHALL be 1 only in WR_RESP; on BVALID&&BREADY the block SHALL capture BRESP into rsp_resp and go to RSP.
REQ-021 ARVALID SHALL be 1 only in RD_ADDR; on ARREADY the block SHALL go to RD_DATA.
REQ-022 RREADY SHALL be 1 only in RD_DATA; on RVALID the block SHALL capture RDATA and RRESP and go to RSP.
REQ-023 All valids SHALL hold, with address, data and strobe stable, until their handshake completes (AXI rule).
REQ-024 AWPROT and ARPROT SHALL be constant 3'b000.
REQ-025 In RSP, rsp_valid SHALL be 1 and the rsp_* fields SHALL be stable; on rsp_ready the block SHALL return to IDLE; a new command SHALL be accepted no earlier than the cycle after that.
REQ-026 For writes, rsp_rdata SHALL be 0 and rsp_write SHALL be 1; for reads, rsp_write SHALL be 0.
REQ-027 Minimum latency SHALL be: write, cmd accept to rsp_valid = 3 cycles with zero-wait slave; read = 3 cycles.
REQ-028 A timeout counter SHALL clear on command accept and increment in every non-IDLE, non-RSP cycle.
REQ-029 When the counter reaches TIMEOUT_CYCLES-1 without completion, the block SHALL deassert all M_AXI valids and readys next cycle, set rsp_resp=2'b10 and rsp_timeout=1, and go to RSP.
REQ-030 A handshake completing in the same cycle as the timeout SHALL take priority; no timeout SHALL be flagged in that case.
REQ-031 rsp_timeout SHALL be 0 for every normal completion; SLVERR/DECERR from the slave SHALL pass through unchanged in rsp_resp.

Reset
REQ-032 On M_AXI_ARESETN low, the block SHALL go immediately to IDLE and set all valids, readys and rsp_* to 0, counter=0 and latched cmd fields=0, including mid-transaction.
REQ-033 After reset release, cmd_ready SHALL be 1 in the first clock edge.

Structure
REQ-034 A shared package sata_axil_pkg SHALL hold the FSM state enum, the AXI response codes (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the AXI_PROT_DEFAULT=3'b000 constant.
REQ-035 The block SHALL be a single module with no sub-modules; the timeout counter width SHALL be $clog2(TIMEOUT_CYCLES).

Verification
REQ-036 The bench SHALL check: write addr 0x08, data 0xDEADBEEF, strb 0xF to the register-file slave -> rsp_resp=00 and rsp_timeout=0; then read 0x08 -> rsp_rdata=0xDEADBEEF.
REQ-037 The bench SHALL check: slave AWREADY 3 cycles before WREADY -> AWVALID drops first, WVALID is held, and exactly one B handshake occurs.
REQ-038 The bench SHALL check: write strb 0x3 with data 0x12345678 over 0xDEADBEEF -> readback 0xDEAD5678.
REQ-039 The bench SHALL check: slave never asserts ARREADY, TIMEOUT_CYCLES=16 -> rsp_valid at cycle 16 after accept with rsp_resp=10 and rsp_timeout=1.
REQ-040 The bench SHALL check: rsp_ready held low 5 cycles -> rsp fields stable, cmd_ready=0 throughout.
REQ-041 The bench SHALL check: reset asserted during WR_RESP -> all outputs 0 asynchronously, and the next command completes normally.

Source files
------------

// File: rtl/sata_axil_pkg.sv
// Shared types and constants for the SATA-side AXI4-Lite command master.
package sata_axil_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_e;

  // AXI response codes.
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access.
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage : sata_axil_pkg

// File: rtl/sata_axil_master.sv
// Single-outstanding AXI4-Lite master: accepts one read or write command,
// runs it on the AXI channels, and returns one response. A per-transaction
// watchdog aborts a stalled transaction with SLVERR and rsp_timeout set.
// TIMEOUT_CYCLES must be >= 2; only a 32-bit data width is supported.
module sata_axil_master
  import sata_axil_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // command
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  // AW
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // W
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // B
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // AR
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // R
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int SW    = C_M_AXI_DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  // The watchdog fires while the counter moves to TIMEOUT_CYCLES-1, so the
  // abort lands exactly TIMEOUT_CYCLES cycles after the accept cycle.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             cmd_write_q, cmd_write_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rsp_resp_q, rsp_resp_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  logic cmd_accept;
  logic busy;
  logic timeout_hit;
  logic aw_now;
  logic w_now;

  assign cmd_accept  = (state_q == IDLE) && cmd_valid;
  assign busy        = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                       (state_q == RD_ADDR)      || (state_q == RD_DATA);
  assign timeout_hit = (cnt_q >= CNT_FIRE);

  // A channel is done once its ready was seen while its valid was up; with
  // the done flag clear the valid is high, so ready alone means handshake.
  assign aw_now = aw_done_q || M_AXI_AWREADY;
  assign w_now  = w_done_q  || M_AXI_WREADY;

  // Next-state, command latch and response capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    cmd_write_d   = cmd_write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_write_d   = cmd_write;
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          wstrb_d       = cmd_wstrb;
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          rsp_resp_d    = AXI_RESP_OKAY;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = cmd_write ? WR_ADDR_DATA : RD_ADDR;
        end
      end

      WR_ADDR_DATA: begin
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) begin
          state_d = WR_RESP;
        end else if (timeout_hit) begin
          rsp_resp_d    = AXI_RESP_SLVERR;
          rsp_timeout_d = 1'b1;
          state_d       = RSP;
        end
      end

      WR_RESP: begin
        if (M_AXI_BVALID) begin
          rsp_resp_d = M_AXI_BRESP;
          state_d    = RSP;
        end else if (timeout_hit) begin
          rsp_resp_d    = AXI_RESP_SLVERR;
          rsp_timeout_d = 1'b1;
          state_d       = RSP;
        end
      end

      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = RD_DATA;
        end else if (timeout_hit) begin
          rsp_resp_d    = AXI_RESP_SLVERR;
          rsp_timeout_d = 1'b1;
          state_d       = RSP;
        end
      end

      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          state_d     = RSP;
        end else if (timeout_hit) begin
          rsp_resp_d    = AXI_RESP_SLVERR;
          rsp_timeout_d = 1'b1;
          state_d       = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Watchdog: cleared on accept, counts active cycles, saturates at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (cmd_accept) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers; reset returns to an idle, all-zero master.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= IDLE;
      cmd_write_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cnt_q         <= '0;
      rsp_resp_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q       <= state_d;
      cmd_write_q   <= cmd_write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cnt_q         <= cnt_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Handshake outputs decode straight from registered state: glitch-free
  // with respect to inputs and held stable until the handshake completes.
  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RSP);
  assign rsp_write     = cmd_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_AWVALID = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_ARVALID = (state_q == RD_ADDR);
  assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule : sata_axil_master

// File: tb/tb_sata_axil_master.sv
// Directed bench for sata_axil_master with a small register-file slave.
module tb_sata_axil_master;
  import sata_axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_ready = 1'b0;
  logic          cmd_ready, rsp_valid, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;

  logic          s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0;
  logic          s_arready = 1'b0, s_rvalid = 1'b0;
  logic [1:0]    s_bresp = '0, s_rresp = '0;
  logic [DW-1:0] s_rdata = '0;

  sata_axil_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .M_AXI_AWADDR (m_awaddr),
    .M_AXI_AWPROT (m_awprot),
    .M_AXI_AWVALID(m_awvalid),
    .M_AXI_AWREADY(s_awready),
    .M_AXI_WDATA  (m_wdata),
    .M_AXI_WSTRB  (m_wstrb),
    .M_AXI_WVALID (m_wvalid),
    .M_AXI_WREADY (s_wready),
    .M_AXI_BRESP  (s_bresp),
    .M_AXI_BVALID (s_bvalid),
    .M_AXI_BREADY (m_bready),
    .M_AXI_ARADDR (m_araddr),
    .M_AXI_ARPROT (m_arprot),
    .M_AXI_ARVALID(m_arvalid),
    .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA  (s_rdata),
    .M_AXI_RRESP  (s_rresp),
    .M_AXI_RVALID (s_rvalid),
    .M_AXI_RREADY (m_rready)
  );

  // ---------------- slave model (acts on the falling edge) ----------------
  int         aw_wait    = 0;
  int         w_wait     = 0;
  bit         ar_never   = 1'b0;
  bit         b_hold     = 1'b0;
  logic [1:0] b_resp_cfg = AXI_RESP_OKAY;
  int         b_count    = 0;

  logic [DW-1:0] mem [8] = '{default: '0};
  bit            aw_fire, w_fire, b_fire, ar_fire, r_fire, have_aw, have_w;
  logic [AW-1:0] aw_addr_l, ar_addr_l;
  logic [DW-1:0] w_data_l;
  logic [3:0]    w_strb_l;
  int            aw_cnt, w_cnt;

  // Retire handshakes from the rising edge just passed, then set the readys
  // and valids for the next rising edge and note which will complete there.
  always @(negedge clk) begin
    if (!rst_n) begin
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata  = '0;   s_rresp = '0;
      aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0; ar_fire = 1'b0; r_fire = 1'b0;
      have_aw = 1'b0; have_w = 1'b0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (aw_fire) begin have_aw = 1'b1; s_awready = 1'b0; aw_cnt = 0; end
      if (w_fire)  begin have_w  = 1'b1; s_wready  = 1'b0; w_cnt  = 0; end
      if (b_fire)  begin s_bvalid = 1'b0; b_count++; end
      if (r_fire)  s_rvalid = 1'b0;
      if (ar_fire) begin
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = mem[ar_addr_l[4:2]];
        s_rresp   = AXI_RESP_OKAY;
      end
      if (have_aw && have_w && !s_bvalid && !b_hold) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_l[b]) mem[aw_addr_l[4:2]][8*b +: 8] = w_data_l[8*b +: 8];
        s_bvalid = 1'b1;
        s_bresp  = b_resp_cfg;
        have_aw  = 1'b0;
        have_w   = 1'b0;
      end
      if (m_awvalid && !s_awready && !have_aw) begin
        if (aw_cnt >= aw_wait) s_awready = 1'b1; else aw_cnt++;
      end
      if (m_wvalid && !s_wready && !have_w) begin
        if (w_cnt >= w_wait) s_wready = 1'b1; else w_cnt++;
      end
      if (m_arvalid && !s_arready && !ar_never) s_arready = 1'b1;

      aw_fire = m_awvalid && s_awready;
      if (aw_fire) aw_addr_l = m_awaddr;
      w_fire = m_wvalid && s_wready;
      if (w_fire) begin w_data_l = m_wdata; w_strb_l = m_wstrb; end
      b_fire  = s_bvalid && m_bready;
      ar_fire = m_arvalid && s_arready;
      if (ar_fire) ar_addr_l = m_araddr;
      r_fire  = s_rvalid && m_rready;
    end
  end

  // ---------------- checking and stimulus ----------------
  int total = 0;
  int bad   = 0;
  int lat   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a command and return in the first cycle after it was accepted.
  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_accept_bound", 64'(n < 20), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    lat = 1;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [3:0] s, input int exp_lat,
                     input logic [1:0] exp_resp, input logic exp_to, input logic [DW-1:0] exp_rdata);
    issue(wr, a, d, s);
    wait_rsp(tag, exp_lat);
    check({tag, "_resp"},    64'(rsp_resp),    64'(exp_resp));
    check({tag, "_timeout"}, 64'(rsp_timeout), 64'(exp_to));
    check({tag, "_write"},   64'(rsp_write),   64'(wr));
    check({tag, "_rdata"},   64'(rsp_rdata),   64'(exp_rdata));
    finish_rsp();
  endtask

  logic [35:0] snap;
  bit          stable;
  int          b_base;

  initial begin
    // Reset state.
    #1;
    check("rst_valids", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}), 64'(0));
    check("rst_prot", 64'({m_awprot, m_arprot}), 64'(0));
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Basic write then read back.
    txn("wr08", 1'b1, 5'h08, 32'hDEADBEEF, 4'hF, 3, AXI_RESP_OKAY, 1'b0, 32'h0);
    txn("rd08", 1'b0, 5'h08, 32'h0, 4'h0, 3, AXI_RESP_OKAY, 1'b0, 32'hDEADBEEF);

    // Partial strobe: low two bytes only.
    txn("wrstb", 1'b1, 5'h08, 32'h12345678, 4'h3, 3, AXI_RESP_OKAY, 1'b0, 32'h0);
    txn("rdstb", 1'b0, 5'h08, 32'h0, 4'h0, 3, AXI_RESP_OKAY, 1'b0, 32'hDEAD5678);

    // AWREADY three cycles ahead of WREADY.
    aw_wait = 0; w_wait = 3;
    b_base = b_count;
    issue(1'b1, 5'h10, 32'hCAFEF00D, 4'hF);
    check("split_c1_valids", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
    check("split_c1_prot", 64'({m_awprot, m_arprot}), 64'(0));
    @(negedge clk); lat++;
    check("split_c2_valids", 64'({m_awvalid, m_wvalid}), 64'(2'b01));
    @(negedge clk); lat++;
    check("split_c3_valids", 64'({m_awvalid, m_wvalid}), 64'(2'b01));
    check("split_c3_wdata", 64'({m_wdata, m_wstrb}), 64'({32'hCAFEF00D, 4'hF}));
    wait_rsp("split", 6);
    check("split_resp", 64'({rsp_resp, rsp_timeout}), 64'(0));
    finish_rsp();
    @(negedge clk);
    check("split_b_count", 64'(b_count - b_base), 64'(1));
    w_wait = 0;
    txn("rd10", 1'b0, 5'h10, 32'h0, 4'h0, 3, AXI_RESP_OKAY, 1'b0, 32'hCAFEF00D);

    // Slave error passes through without a timeout flag.
    b_resp_cfg = AXI_RESP_SLVERR;
    txn("slverr", 1'b1, 5'h14, 32'h1, 4'hF, 3, AXI_RESP_SLVERR, 1'b0, 32'h0);
    b_resp_cfg = AXI_RESP_DECERR;
    txn("decerr", 1'b1, 5'h14, 32'h2, 4'hF, 3, AXI_RESP_DECERR, 1'b0, 32'h0);
    b_resp_cfg = AXI_RESP_OKAY;

    // Read timeout: ARREADY never comes.
    ar_never = 1'b1;
    issue(1'b0, 5'h04, 32'h0, 4'h0);
    wait_rsp("rdto", TO);
    check("rdto_resp", 64'(rsp_resp), 64'(AXI_RESP_SLVERR));
    check("rdto_timeout", 64'(rsp_timeout), 64'(1));
    check("rdto_arvalid", 64'({m_arvalid, m_rready}), 64'(0));
    check("rdto_rdata", 64'(rsp_rdata), 64'(0));
    finish_rsp();
    ar_never = 1'b0;

    // Response held for five cycles with rsp_ready low.
    issue(1'b0, 5'h08, 32'h0, 4'h0);
    wait_rsp("hold", 3);
    snap = {rsp_write, rsp_rdata, rsp_resp, rsp_timeout};
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({rsp_write, rsp_rdata, rsp_resp, rsp_timeout} !== snap || cmd_ready !== 1'b0 || rsp_valid !== 1'b1)
        stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'(1));
    check("hold_rdata", 64'(rsp_rdata), 64'(32'hDEAD5678));
    finish_rsp();

    // Asynchronous reset while waiting for B.
    b_hold = 1'b1;
    issue(1'b1, 5'h0C, 32'hA5A5A5A5, 4'hF);
    @(negedge clk);
    check("rstmid_bready", 64'(m_bready), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valids", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}), 64'(0));
    check("rstmid_rsp", 64'({rsp_write, rsp_timeout, rsp_resp}), 64'(0));
    check("rstmid_data", 64'({rsp_rdata, m_wdata}), 64'(0));
    check("rstmid_addr", 64'({m_awaddr, m_araddr, m_wstrb}), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    b_hold = 1'b0;
    txn("postrst_wr", 1'b1, 5'h0C, 32'h55AA55AA, 4'hF, 3, AXI_RESP_OKAY, 1'b0, 32'h0);
    txn("postrst_rd", 1'b0, 5'h0C, 32'h0, 4'h0, 3, AXI_RESP_OKAY, 1'b0, 32'h55AA55AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sata_axil_master
